// File: rtl/mult_div_unit_if.sv
// Handshake and operand/result bundle between the control unit (master) and the
// iterative multiply/divide unit (slave).
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

interface mult_div_unit_if #(
  parameter int DATA_WIDTH = `DATA_SIZE
);
  logic                  start;
  logic [2:0]            op;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic                  hi_we;
  logic                  lo_we;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;

  modport master (
    output start, op, op_a, op_b, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, op_a, op_b, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit writing architectural HI/LO, with MTHI/MTLO.
// Defining MULDIV_ACCUM_EN adds MADD/MADDU (ops 4/5) accumulating into {HI,LO}.
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

// state | meaning
// IDLE  | waiting for start; MTHI/MTLO writes accepted
// CALC  | one shift-add or restoring-divide step per cycle
// FIX   | sign correction, HI/LO write, one-cycle done pulse
module mult_div_unit #(
  parameter int DATA_WIDTH = `DATA_SIZE,
  parameter int CNT_WIDTH  = 6
) (
  input logic            clk,
  input logic            reset,
  mult_div_unit_if.slave bus
);
  localparam int W = DATA_WIDTH;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(W - 1);

  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]       acc_q, acc_d;
  logic [W-1:0]         opb_q, opb_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_a_q, neg_a_d;
  logic                 div_zero_q, div_zero_d;
  logic [W-1:0]         hi_q, hi_d;
  logic [W-1:0]         lo_q, lo_d;
  logic                 done_q, done_d;
`ifdef MULDIV_ACCUM_EN
  logic                 is_madd_q, is_madd_d;
`endif

  logic           op_legal;
  logic           op_signed;
  logic           op_div;
  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;
  logic [W:0]     add_sum;
  logic [W:0]     trial;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix;
  logic [W-1:0]   rem_fix;

  // Operation decode and operand magnitudes for the launch edge.
  always_comb begin
    op_div    = (bus.op == 3'd2) || (bus.op == 3'd3);
    op_signed = (bus.op == 3'd0) || (bus.op == 3'd2);
`ifdef MULDIV_ACCUM_EN
    op_legal  = (bus.op <= 3'd5);
    op_signed = op_signed || (bus.op == 3'd4);
`else
    op_legal  = (bus.op <= 3'd3);
`endif
    a_mag = (op_signed && bus.op_a[W-1]) ? (~bus.op_a + 1'b1) : bus.op_a;
    b_mag = (op_signed && bus.op_b[W-1]) ? (~bus.op_b + 1'b1) : bus.op_b;
  end

  // acc_q holds {product high, product low} for multiply and {remainder, dividend/quotient}
  // for divide; a negative trial difference shows up as the MSB of the W+1 bit result.
  always_comb begin
    add_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? opb_q : {W{1'b0}})};
    trial    = {acc_q[2*W-1:W], acc_q[W-1]} - {1'b0, opb_q};
    prod_fix = neg_res_q ? (~acc_q + 1'b1) : acc_q;
    quo_fix  = neg_res_q ? (~acc_q[W-1:0] + 1'b1) : acc_q[W-1:0];
    rem_fix  = neg_a_q ? (~acc_q[2*W-1:W] + 1'b1) : acc_q[2*W-1:W];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opb_d      = opb_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_a_d    = neg_a_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
`ifdef MULDIV_ACCUM_EN
    is_madd_d  = is_madd_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.hi_we) hi_d = bus.wdata;
        if (bus.lo_we) lo_d = bus.wdata;
        if (bus.start && op_legal) begin
          state_d    = CALC;
          cnt_d      = '0;
          is_div_d   = op_div;
          neg_a_d    = op_signed && bus.op_a[W-1];
          neg_res_d  = op_signed && (bus.op_a[W-1] ^ bus.op_b[W-1]);
          div_zero_d = op_div && (bus.op_b == '0);
`ifdef MULDIV_ACCUM_EN
          is_madd_d  = (bus.op == 3'd4) || (bus.op == 3'd5);
`endif
          if (op_div) begin
            acc_d = {{W{1'b0}}, a_mag};
            opb_d = b_mag;
          end else begin
            acc_d = {{W{1'b0}}, b_mag};
            opb_d = a_mag;
          end
        end
      end

      CALC: begin
        if (is_div_q) begin
          if (!trial[W]) acc_d = {trial[W-1:0], acc_q[W-2:0], 1'b1};
          else           acc_d = {acc_q[2*W-2:0], 1'b0};
        end else begin
          acc_d = {add_sum, acc_q[W-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = FIX;
      end

      FIX: begin
        if (is_div_q) begin
          // Divide by zero: quotient all ones, remainder restores to the dividend.
          lo_d = div_zero_q ? {W{1'b1}} : quo_fix;
          hi_d = rem_fix;
        end else begin
`ifdef MULDIV_ACCUM_EN
          if (is_madd_q) {hi_d, lo_d} = {hi_q, lo_q} + prod_fix;
          else           {hi_d, lo_d} = prod_fix;
`else
          {hi_d, lo_d} = prod_fix;
`endif
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opb_q      <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_a_q    <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
`ifdef MULDIV_ACCUM_EN
      is_madd_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opb_q      <= opb_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_a_q    <= neg_a_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
`ifdef MULDIV_ACCUM_EN
      is_madd_q  <= is_madd_d;
`endif
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule
